// File: rtl/ac_sched_pkg.sv
// ---------------------------------------------------------------------------
// ac_sched_pkg
// Shared definitions for the AC run scheduler slice: the FSM state encoding
// and the per-slice constants (coefficients per 8x8 block and the codebook
// history values a fresh slice starts from).
// ---------------------------------------------------------------------------
package ac_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // AC coefficients per 8x8 block (DC is handled elsewhere).
  localparam int          COEFS_PER_BLOCK = 63;
  // Codebook-selection history seen by the first code of every slice.
  localparam logic [15:0] INIT_PREV_RUN   = 16'd4;
  localparam logic [15:0] INIT_PREV_LEVEL = 16'd2;

endpackage : ac_sched_pkg

// File: rtl/ac_run_scheduler_if.sv
// ---------------------------------------------------------------------------
// ac_run_scheduler_if
// Handshake and result bundle of the AC run scheduler.
//   slave  : the scheduler (consumes start/block_num/coef, drives results)
//   master : the producer/consumer side around it
// Signals:
//   start, block_num        slice start pulse and block count
//   coef_valid, coef        coefficient stream (interleaved scan order)
//   coef_ready              scheduler accepts coef this cycle
//   run_valid, run, abs_level, sign, prev_run, prev_level
//                           one code per strobe plus its codebook history
//   ac_vlc_output_flush     end-of-slice pulse to the AC output stage
//   busy, done              slice in progress / completion pulse
// ---------------------------------------------------------------------------
interface ac_run_scheduler_if;

  logic               start;
  logic [7:0]         block_num;
  logic               coef_valid;
  logic signed [15:0] coef;
  logic               coef_ready;
  logic               run_valid;
  logic [15:0]        run;
  logic [15:0]        abs_level;
  logic               sign;
  logic [15:0]        prev_run;
  logic [15:0]        prev_level;
  logic               ac_vlc_output_flush;
  logic               busy;
  logic               done;

  modport master (
    output start, block_num, coef_valid, coef,
    input  coef_ready, run_valid, run, abs_level, sign, prev_run, prev_level,
           ac_vlc_output_flush, busy, done
  );

  modport slave (
    input  start, block_num, coef_valid, coef,
    output coef_ready, run_valid, run, abs_level, sign, prev_run, prev_level,
           ac_vlc_output_flush, busy, done
  );

endinterface : ac_run_scheduler_if

// File: rtl/ac_level_abs.sv
// ---------------------------------------------------------------------------
// ac_level_abs
// Combinational magnitude/sign split of a signed 16-bit coefficient.
// Ports:
//   coef      in  16  signed coefficient
//   abs_level out 16  |coef| as unsigned; -32768 gives 32768 (no saturation)
//   sign      out 1   1 when coef is negative
// ---------------------------------------------------------------------------
module ac_level_abs (
  input  logic signed [15:0] coef,
  output logic [15:0]        abs_level,
  output logic               sign
);

  logic [16:0] coef_ext;
  logic [16:0] mag;
  logic        unused_mag_msb;

  // Negating in 17 bits makes -32768 representable; the magnitude always
  // fits the low 16 bits as an unsigned value, so bit 16 is never needed.
  assign coef_ext       = {coef[15], coef};
  assign mag            = coef[15] ? (~coef_ext + 17'd1) : coef_ext;
  assign abs_level      = mag[15:0];
  assign sign           = coef[15];
  assign unused_mag_msb = mag[16];

endmodule : ac_level_abs

// File: rtl/ac_run_scheduler.sv
// ---------------------------------------------------------------------------
// ac_run_scheduler
// Turns a slice of quantised AC coefficients into (run, level, sign) codes,
// each tagged with the previous code's run/level for codebook selection.
// Zero coefficients extend the current run; a nonzero one emits a code the
// following cycle. Trailing zeros are swallowed. After the last coefficient
// of the slice a single flush pulse goes to the output stage, then done.
//
// Ports:
//   clock  in   sole clock, rising edge
//   reset  in   asynchronous active-high reset
//   bus    ac_run_scheduler_if.slave (see interface header)
//   stat_codes, stat_zeros  out 16  (only with AC_SCHED_STATS_EN defined)
//                           codes emitted / zeros consumed in the last slice
//
// Parameters:
//   MAX_BLOCKS  largest block_num honoured; larger requests are clamped
//
// Build option: define AC_SCHED_STATS_EN to add the per-slice statistics.
// ---------------------------------------------------------------------------
module ac_run_scheduler
  import ac_sched_pkg::*;
#(
  parameter int MAX_BLOCKS = 255
) (
  input  logic               clock,
  input  logic               reset,
  ac_run_scheduler_if.slave  bus
`ifdef AC_SCHED_STATS_EN
  ,
  output logic [15:0]        stat_codes,
  output logic [15:0]        stat_zeros
`endif
);

  sched_state_e state_q, state_d;

  logic [15:0] remaining_q;     // coefficients still to accept in this slice
  logic [15:0] run_cnt_q;       // zeros since the last nonzero coefficient
  logic [15:0] hist_run_q;      // run of the most recent code
  logic [15:0] hist_level_q;    // level of the most recent code

  logic        run_valid_q;
  logic [15:0] run_q;
  logic [15:0] abs_level_q;
  logic        sign_q;
  logic [15:0] prev_run_q;
  logic [15:0] prev_level_q;

  logic [15:0] abs_level_c;
  logic        sign_c;
  logic [15:0] blk_eff;
  logic        start_acc;
  logic        xfer;
  logic        coef_nz;
  logic        last_xfer;

  ac_level_abs u_level_abs (
    .coef      (bus.coef),
    .abs_level (abs_level_c),
    .sign      (sign_c)
  );

  assign blk_eff   = ({8'd0, bus.block_num} > 16'(MAX_BLOCKS)) ? 16'(MAX_BLOCKS)
                                                              : {8'd0, bus.block_num};
  assign start_acc = (state_q == ST_IDLE) && bus.start;
  assign xfer      = bus.coef_valid && (state_q == ST_SCAN);
  assign coef_nz   = |bus.coef;
  assign last_xfer = xfer && (remaining_q == 16'd1);

  // Next state and state-decoded outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d                 = state_q;
    bus.coef_ready          = 1'b0;
    bus.ac_vlc_output_flush = 1'b0;
    bus.done                = 1'b0;
    bus.busy                = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_d = (blk_eff == 16'd0) ? ST_FLUSH : ST_SCAN;
      end
      ST_SCAN: begin
        bus.coef_ready = 1'b1;
        if (last_xfer) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // A code from the final coefficient may still be on the outputs;
        // the flush waits one cycle so the two never coincide.
        if (!run_valid_q) begin
          bus.ac_vlc_output_flush = 1'b1;
          state_d                 = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      run_cnt_q    <= '0;
      hist_run_q   <= INIT_PREV_RUN;
      hist_level_q <= INIT_PREV_LEVEL;
      run_valid_q  <= 1'b0;
      run_q        <= '0;
      abs_level_q  <= '0;
      sign_q       <= 1'b0;
      prev_run_q   <= '0;
      prev_level_q <= '0;
    end else begin
      state_q     <= state_d;
      run_valid_q <= 1'b0;

      if (start_acc) begin
        remaining_q  <= 16'(COEFS_PER_BLOCK) * blk_eff;
        run_cnt_q    <= '0;
        hist_run_q   <= INIT_PREV_RUN;
        hist_level_q <= INIT_PREV_LEVEL;
      end

      if (xfer) begin
        remaining_q <= remaining_q - 16'd1;
        if (coef_nz) begin
          run_valid_q  <= 1'b1;
          run_q        <= run_cnt_q;
          abs_level_q  <= abs_level_c;
          sign_q       <= sign_c;
          prev_run_q   <= hist_run_q;
          prev_level_q <= hist_level_q;
          hist_run_q   <= run_cnt_q;
          hist_level_q <= abs_level_c;
          run_cnt_q    <= '0;
        end else begin
          run_cnt_q <= run_cnt_q + 16'd1;
        end
      end
    end
  end

  assign bus.run_valid  = run_valid_q;
  assign bus.run        = run_q;
  assign bus.abs_level  = abs_level_q;
  assign bus.sign       = sign_q;
  assign bus.prev_run   = prev_run_q;
  assign bus.prev_level = prev_level_q;

`ifdef AC_SCHED_STATS_EN
  logic [15:0] stat_codes_q;
  logic [15:0] stat_zeros_q;

  // Cleared when a slice is accepted, then held after done until the next.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_codes_q <= '0;
      stat_zeros_q <= '0;
    end else if (start_acc) begin
      stat_codes_q <= '0;
      stat_zeros_q <= '0;
    end else if (xfer) begin
      if (coef_nz) stat_codes_q <= stat_codes_q + 16'd1;
      else         stat_zeros_q <= stat_zeros_q + 16'd1;
    end
  end

  assign stat_codes = stat_codes_q;
  assign stat_zeros = stat_zeros_q;
`endif

endmodule : ac_run_scheduler

// File: tb/tb_ac_run_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ac_run_scheduler
// Self-checking bench for ac_run_scheduler. Expected codes come either from
// hand-written constants or from a reference model that walks the stimulus
// list counting zeros and emitting (run, |v|, v<0, previous run/level).
// Define AC_SCHED_STATS_EN to also check the statistics outputs.
// ---------------------------------------------------------------------------
module tb_ac_run_scheduler;

  typedef struct packed {
    logic [15:0] run;
    logic [15:0] lvl;
    logic        sgn;
    logic [15:0] prun;
    logic [15:0] plvl;
  } code_t;

  typedef struct {
    int                 pos;
    logic signed [15:0] value;
    logic [15:0]        e_run;
    logic [15:0]        e_lvl;
    logic               e_sign;
  } vec_t;

  logic clock;
  logic reset;

  ac_run_scheduler_if bus ();

`ifdef AC_SCHED_STATS_EN
  logic [15:0] stat_codes;
  logic [15:0] stat_zeros;
`endif

  ac_run_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus)
`ifdef AC_SCHED_STATS_EN
    ,
    .stat_codes (stat_codes),
    .stat_zeros (stat_zeros)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- monitor (sole writer of its variables) ----------------
  int    cyc = 0;
  code_t got_q[$];
  int    n_flush = 0, n_done = 0, n_overlap = 0, n_ready = 0;
  int    flush_cyc = -1, done_cyc = -1;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (bus.run_valid)
      got_q.push_back('{bus.run, bus.abs_level, bus.sign, bus.prev_run, bus.prev_level});
    if (bus.ac_vlc_output_flush) begin n_flush++; flush_cyc = cyc; end
    if (bus.done) begin n_done++; done_cyc = cyc; end
    if (bus.run_valid && bus.ac_vlc_output_flush) n_overlap++;
    if (bus.coef_ready) n_ready++;
  end

  // ---------------- stimulus and expectations ----------------
  logic signed [15:0] stim_q[$];
  code_t              exp_q[$];

  function automatic code_t mk(input int r, input int l, input bit s, input int pr, input int pl);
    code_t c;
    c.run = 16'(r); c.lvl = 16'(l); c.sgn = s; c.prun = 16'(pr); c.plvl = 16'(pl);
    return c;
  endfunction

  function automatic void zeros_stim(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(16'sd0);
  endfunction

  // Reference model: walk the slice, count zeros, emit on every nonzero.
  function automatic void build_model();
    int zeros, v, a, pr, pl;
    exp_q.delete();
    zeros = 0; pr = 4; pl = 2;
    foreach (stim_q[i]) begin
      v = int'(stim_q[i]);
      if (v == 0) zeros++;
      else begin
        a = (v < 0) ? -v : v;
        exp_q.push_back(mk(zeros, a, v < 0, pr, pl));
        pr = zeros; pl = a; zeros = 0;
      end
    end
  endfunction

  // Runs one slice from stim_q and compares against exp_q.
  task automatic run_slice(input int blk, input bit toggle, input bit stray, input string nm);
    int  base_codes, base_flush, base_done, base_ovl, base_ready;
    int  idx, budget, ref_cyc, exp_flush, wait_b;
    bit  acc, timed_out, last_nz;
`ifdef AC_SCHED_STATS_EN
    int  nzeros;
`endif
    base_codes = got_q.size(); base_flush = n_flush; base_done = n_done;
    base_ovl = n_overlap; base_ready = n_ready;

    bus.block_num = 8'(blk);
    bus.start     = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check({nm, " busy after start"}, bus.busy, 1'b1);

    ref_cyc = cyc; idx = 0; budget = 63 * blk * 6 + 20; timed_out = 0;
    while (idx < stim_q.size()) begin
      if (budget == 0) begin timed_out = 1; break; end
      budget--;
      bus.coef_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.coef       = stim_q[idx];
      if (stray) bus.start = 1'($urandom_range(0, 1));
      acc = bus.coef_valid && bus.coef_ready;
      @(posedge clock); #1;
      if (acc) begin idx++; ref_cyc = cyc; end
    end
    bus.coef_valid = 1'b0; bus.start = 1'b0; bus.coef = '0;
    check({nm, " coef timeout"}, timed_out, 1'b0);

    wait_b = 20;
    while (n_done == base_done && wait_b > 0) begin @(posedge clock); #1; wait_b--; end
    repeat (3) begin @(posedge clock); #1; end

    last_nz   = (stim_q.size() > 0) && (stim_q[stim_q.size()-1] != 0);
    exp_flush = ref_cyc + (last_nz ? 1 : 0);
    check({nm, " flush count"}, n_flush - base_flush, 1);
    check({nm, " done count"}, n_done - base_done, 1);
    check({nm, " flush cycle"}, flush_cyc, exp_flush);
    check({nm, " done after flush"}, done_cyc, flush_cyc + 1);
    check({nm, " flush/code overlap"}, n_overlap - base_ovl, 0);
    check({nm, " busy after done"}, bus.busy, 1'b0);
    if (blk == 0) check({nm, " coef_ready seen"}, n_ready - base_ready, 0);
    check({nm, " code count"}, got_q.size() - base_codes, exp_q.size());
    foreach (exp_q[i])
      if (base_codes + i < got_q.size())
        check($sformatf("%s code %0d", nm, i), got_q[base_codes + i], exp_q[i]);
`ifdef AC_SCHED_STATS_EN
    nzeros = 0;
    foreach (stim_q[i]) if (stim_q[i] == 0) nzeros++;
    check({nm, " stat_codes"}, stat_codes, exp_q.size());
    check({nm, " stat_zeros"}, stat_zeros, nzeros);
`endif
  endtask

  function automatic void random_stim(input int n);
    int r;
    logic signed [15:0] v;
    stim_q.delete();
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       v = 16'sd0;
      else if (r == 6) v = 16'sh8000;
      else if (r == 7) v = 16'($urandom_range(0, 20)) - 16'sd10;
      else             v = 16'($urandom);
      stim_q.push_back(v);
    end
  endfunction

  vec_t vecs[5];

  initial begin
    int fed, budget, bf, bd;
    bit acc;

    vecs[0] = '{0,  16'sd1,      16'd0,  16'd1,     1'b0};
    vecs[1] = '{62, -16'sd32768, 16'd62, 16'd32768, 1'b1};
    vecs[2] = '{10, -16'sd1,     16'd10, 16'd1,     1'b1};
    vecs[3] = '{5,  16'sd32767,  16'd5,  16'd32767, 1'b0};
    vecs[4] = '{1,  -16'sd300,   16'd1,  16'd300,   1'b1};

    bus.start = 1'b0; bus.block_num = '0; bus.coef_valid = 1'b0; bus.coef = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset run_valid", bus.run_valid, 1'b0);
    check("reset flush", bus.ac_vlc_output_flush, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset busy", bus.busy, 1'b0);
    check("reset coef_ready", bus.coef_ready, 1'b0);
    check("reset code outputs", {bus.run, bus.abs_level, bus.sign, bus.prev_run, bus.prev_level}, '0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Single-code slices: one nonzero at a chosen scan position.
    for (int t = 0; t < 5; t++) begin
      zeros_stim(63);
      stim_q[vecs[t].pos] = vecs[t].value;
      exp_q.delete();
      exp_q.push_back(mk(int'(vecs[t].e_run), int'(vecs[t].e_lvl), vecs[t].e_sign, 4, 2));
      run_slice(1, 1'b0, 1'b0, $sformatf("vec%0d", t));
    end

    // Two codes with history chaining, trailing zeros swallowed.
    zeros_stim(63);
    stim_q[0] = 16'sd5; stim_q[3] = -16'sd3;
    exp_q.delete();
    exp_q.push_back(mk(0, 5, 1'b0, 4, 2));
    exp_q.push_back(mk(2, 3, 1'b1, 0, 5));
    run_slice(1, 1'b0, 1'b0, "two codes");

    // All-zero two-block slice.
    zeros_stim(126);
    exp_q.delete();
    run_slice(2, 1'b0, 1'b0, "all zero");

    // Empty slice.
    stim_q.delete();
    exp_q.delete();
    run_slice(0, 1'b0, 1'b0, "empty slice");

    // Reset in the middle of a four-block slice, with a code pending.
    zeros_stim(252);
    stim_q[3] = 16'sd12; stim_q[20] = -16'sd7; stim_q[29] = 16'sd99;
    bus.block_num = 8'd4; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    fed = 0; budget = 200;
    while (fed < 30 && budget > 0) begin
      budget--;
      bus.coef_valid = 1'b1; bus.coef = stim_q[fed];
      acc = bus.coef_ready;
      @(posedge clock); #1;
      if (acc) fed++;
    end
    bus.coef_valid = 1'b0; bus.coef = '0;
    check("mid-slice coefs fed", fed, 30);
    check("mid-slice pending code", bus.run_valid, 1'b1);
    bf = n_flush; bd = n_done;
    #2 reset = 1'b1;
    #1;
    check("async reset run_valid", bus.run_valid, 1'b0);
    check("async reset busy", bus.busy, 1'b0);
    check("async reset coef_ready", bus.coef_ready, 1'b0);
    check("async reset code outputs", {bus.run, bus.abs_level, bus.sign, bus.prev_run, bus.prev_level}, '0);
`ifdef AC_SCHED_STATS_EN
    check("async reset stats", {stat_codes, stat_zeros}, '0);
`endif
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    check("no flush after reset", n_flush - bf, 0);
    check("no done after reset", n_done - bd, 0);

    zeros_stim(63);
    stim_q[2] = 16'sd9;
    exp_q.delete();
    exp_q.push_back(mk(2, 9, 1'b0, 4, 2));
    run_slice(1, 1'b0, 1'b0, "fresh after reset");

    // Random slices, each run with toggling valid plus stray starts and
    // again with continuous valid; both must match the model.
    for (int t = 0; t < 6; t++) begin
      random_stim(63 * $urandom_range(1, 3));
      build_model();
      run_slice(stim_q.size() / 63, 1'b1, 1'b1, $sformatf("rand%0d toggled", t));
      run_slice(stim_q.size() / 63, 1'b0, 1'b0, $sformatf("rand%0d steady", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ac_run_scheduler
